// File: rtl/fpmul_result_packer.sv
// Generic first-word-fall-through FIFO; the head is read straight from storage.
// Latency: 1 cycle push to head_vld; full push+pop throughput.
// Backpressure: pop only on head_vld && pop_rdy; a push while full must coincide with a pop.
module fpmul_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign head_vld = (count != '0);
    assign pop      = head_vld && pop_rdy;
    // Gating keeps the head at zero while empty, including straight out of reset.
    assign head_dat = head_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_vld, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    no_push_when_full: assert property (
        @(posedge clk) disable iff (rst) !(push_vld && (count == CW'(DEPTH)) && !pop)
    );
endmodule

// Packs normalised FP-multiply results (special values substituted) into a FWFT FIFO.
// Latency: LATENCY+1 cycles from accepted issue to out_valid.
// Backpressure: out_valid/out_ready at the output; issue_ready credits ensure every arrival finds space.
module fpmul_result_packer #(
    parameter int LATENCY    = 4,
    parameter int SIGN_DELAY = 1,
    parameter int DEPTH      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        in_sign,
    input  logic [6:0]  in_exp,
    input  logic [15:0] in_mantissa,
    input  logic        in_overflow,
    input  logic        in_underflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        sticky_ovf,
    output logic        sticky_unf,
    input  logic        clear_flags
);
    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic [23:0] word;
    } res_t;

    logic [LATENCY-1:0]     inflight_sr;
    logic                   accept;
    logic                   arrive;
    logic                   sign_aligned;
    res_t                   packed_res;
    res_t                   head_res;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [31:0]            occupancy;

    assign accept = issue_valid && issue_ready;
    assign arrive = inflight_sr[LATENCY-1];

    // One bit per pipeline stage; the MSB lines up with the normaliser outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_sr <= '0;
        end else begin
            inflight_sr[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                inflight_sr[i] <= inflight_sr[i-1];
            end
        end
    end

    generate
        if (SIGN_DELAY == 0) begin : g_sign_direct
            assign sign_aligned = in_sign;
        end else begin : g_sign_delay
            logic [SIGN_DELAY-1:0] sign_sr;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sign_sr <= '0;
                end else begin
                    sign_sr[0] <= in_sign;
                    for (int i = 1; i < SIGN_DELAY; i++) begin
                        sign_sr[i] <= sign_sr[i-1];
                    end
                end
            end
            assign sign_aligned = sign_sr[SIGN_DELAY-1];
        end
    endgenerate

    // Overflow takes priority when the normaliser raises both flags.
    always_comb begin
        packed_res = '0;
        if (in_overflow) begin
            packed_res.word = {sign_aligned, 7'h7F, 16'h0000};
            packed_res.ovf  = 1'b1;
        end else if (in_underflow) begin
            packed_res.word = {sign_aligned, 7'h00, 16'h0000};
            packed_res.unf  = 1'b1;
        end else begin
            packed_res.word = {sign_aligned, in_exp, in_mantissa};
        end
    end

    // Results already issued hold a FIFO slot until they pop, so arrivals never overflow.
    always_comb begin
        occupancy = 32'(fifo_count);
        for (int i = 0; i < LATENCY; i++) begin
            occupancy = occupancy + 32'(inflight_sr[i]);
        end
    end

    assign issue_ready = (occupancy < 32'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else if (clear_flags) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else if (arrive) begin
            sticky_ovf <= sticky_ovf | packed_res.ovf;
            sticky_unf <= sticky_unf | packed_res.unf;
        end
    end

    fpmul_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (arrive),
        .push_dat (packed_res),
        .pop_rdy  (out_ready),
        .head_vld (out_valid),
        .head_dat (head_res),
        .count    (fifo_count)
    );

    assign out_data = head_res.word;
    assign out_ovf  = head_res.ovf;
    assign out_unf  = head_res.unf;
endmodule

// File: tb/tb_fpmul_result_packer.sv
// Directed bench for fpmul_result_packer: a normaliser stand-in feeds arrivals, a scoreboard checks pops.
module tb_fpmul_result_packer;
    localparam int LAT = 4;
    localparam int SD  = 1;

    typedef struct packed {
        logic        s;
        logic [6:0]  e;
        logic [15:0] m;
        logic        o;
        logic        u;
    } pay_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        in_sign = 1'b0;
    logic [6:0]  in_exp = '0;
    logic [15:0] in_mantissa = '0;
    logic        in_overflow = 1'b0;
    logic        in_underflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] out_data;
    logic        out_ovf;
    logic        out_unf;
    logic        sticky_ovf;
    logic        sticky_unf;
    logic        clear_flags = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_pop = 0;
    int a0, p0;

    pay_t           nxt = '0;
    pay_t           pl [LAT];
    logic [LAT-1:0] pv = '0;
    logic           acc = 1'b0;
    logic [25:0]    sb [$];
    logic [25:0]    exp_r;

    fpmul_result_packer #(.LATENCY(LAT), .SIGN_DELAY(SD), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .in_sign      (in_sign),
        .in_exp       (in_exp),
        .in_mantissa  (in_mantissa),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ovf      (out_ovf),
        .out_unf      (out_unf),
        .sticky_ovf   (sticky_ovf),
        .sticky_unf   (sticky_unf),
        .clear_flags  (clear_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pay_t mk(input logic s, input logic [6:0] e, input logic [15:0] m,
                                input logic o, input logic u);
        pay_t p;
        p.s = s; p.e = e; p.m = m; p.o = o; p.u = u;
        return p;
    endfunction

    // Expected {ovf, unf, word} for one result.
    function automatic logic [25:0] pack(input pay_t p);
        if (p.o)      return {2'b10, p.s, 7'h7F, 16'h0000};
        else if (p.u) return {2'b01, p.s, 7'h00, 16'h0000};
        else          return {2'b00, p.s, p.e, p.m};
    endfunction

    // Normaliser stand-in: remembers accepted operands for LAT cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv = '0;
            sb.delete();
        end else begin
            for (int i = LAT-1; i > 0; i--) begin
                pv[i] = pv[i-1];
                pl[i] = pl[i-1];
            end
            pv[0] = acc;
            pl[0] = nxt;
            if (acc) begin
                sb.push_back(pack(nxt));
                n_acc++;
            end
        end
    end

    // Sample handshakes and present normaliser outputs mid-cycle; idle cycles carry poison.
    always @(negedge clk) begin
        if (!rst) begin
            acc = issue_valid && issue_ready;
            if (out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    check("pop_unexpected", {31'b0, out_valid}, 32'h0);
                end else begin
                    exp_r = sb.pop_front();
                    check("pop_order", {6'b0, out_ovf, out_unf, out_data}, {6'b0, exp_r});
                end
            end
        end else begin
            acc = 1'b0;
        end
        if (pv[LAT-1]) begin
            in_exp       = pl[LAT-1].e;
            in_mantissa  = pl[LAT-1].m;
            in_overflow  = pl[LAT-1].o;
            in_underflow = pl[LAT-1].u;
        end else begin
            in_exp       = 7'h2A;
            in_mantissa  = 16'hDEAD;
            in_overflow  = 1'b1;
            in_underflow = 1'b1;
        end
        in_sign = pv[LAT-1-SD] ? pl[LAT-1-SD].s : 1'b1;
    end

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0 && !out_valid && pv == '0) break;
            tick();
        end
        check(tag, sb.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_issue_ready", {31'b0, issue_ready}, 32'h1);
        check("rst_out_data", {8'b0, out_data}, 32'h0);
        check("rst_flags", {28'b0, out_ovf, out_unf, sticky_ovf, sticky_unf}, 32'h0);
        rst = 1'b0;
        tick();

        // 1.5 * 1.5 = 1.125 * 2^1
        nxt = mk(1'b0, 7'd64, 16'h2000, 1'b0, 1'b0);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();
        check("basic_not_early", {31'b0, out_valid}, 32'h0);
        tick();
        check("basic_valid", {31'b0, out_valid}, 32'h1);
        check("basic_data", {8'b0, out_data}, 32'h402000);
        check("basic_flags", {30'b0, out_ovf, out_unf}, 32'h0);
        tick();

        // Overflow held at the head, then cleared flags
        out_ready = 1'b0;
        nxt = mk(1'b1, 7'h12, 16'h1234, 1'b1, 1'b0);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (4) tick();
        check("ovf_data", {8'b0, out_data}, 32'hFF0000);
        check("ovf_flag", {30'b0, out_ovf, out_unf}, 32'h2);
        check("ovf_sticky", {31'b0, sticky_ovf}, 32'h1);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("ovf_sticky_clr", {31'b0, sticky_ovf}, 32'h0);
        out_ready = 1'b1;
        tick();

        // clear_flags on the arrive cycle beats the set
        nxt = mk(1'b1, 7'h40, 16'h0001, 1'b1, 1'b0);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (3) tick();
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("clr_wins_valid", {31'b0, out_valid}, 32'h1);
        check("clr_wins_sticky", {31'b0, sticky_ovf}, 32'h0);
        tick();

        // Both flags: overflow has priority
        out_ready = 1'b0;
        nxt = mk(1'b0, 7'h30, 16'hFFFF, 1'b1, 1'b1);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (4) tick();
        check("both_data", {8'b0, out_data}, 32'h7F0000);
        check("both_flag", {30'b0, out_ovf, out_unf}, 32'h2);
        out_ready = 1'b1;
        tick();

        // Underflow
        out_ready = 1'b0;
        nxt = mk(1'b0, 7'h05, 16'hABCD, 1'b0, 1'b1);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        repeat (4) tick();
        check("unf_data", {8'b0, out_data}, 32'h000000);
        check("unf_flag", {30'b0, out_ovf, out_unf}, 32'h1);
        check("unf_sticky", {31'b0, sticky_unf}, 32'h1);
        drain("drain_directed");

        // Backpressure: credits stop issue at eight results
        a0 = n_acc;
        p0 = n_pop;
        out_ready = 1'b0;
        issue_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            nxt = mk(i[0], 7'(i + 10), 16'(16'h0100 + i), 1'b0, 1'b0);
            if (i == 10) check("bp_head_mid", {8'b0, out_data}, 32'h0A0100);
            tick();
        end
        check("bp_accepts", n_acc - a0, 8);
        check("bp_issue_ready", {31'b0, issue_ready}, 32'h0);
        check("bp_head_end", {8'b0, out_data}, 32'h0A0100);
        nxt = mk(1'b1, 7'h11, 16'h0BBB, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ready_back", {31'b0, issue_ready}, 32'h1);
        check("bp_accepts_hold", n_acc - a0, 8);
        tick();
        issue_valid = 1'b0;
        check("bp_accepts_more", n_acc - a0, 9);
        drain("drain_bp");
        check("bp_pops", n_pop - p0, 9);

        // Streaming at full throughput
        a0 = n_acc;
        p0 = n_pop;
        out_ready = 1'b1;
        issue_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            nxt = mk(i[0], 7'(i), 16'(i * 3 + 1), (i % 17) == 5, (i % 11) == 3);
            check("stream_ready", {31'b0, issue_ready}, 32'h1);
            if (i >= 6) begin
                check("stream_valid", {31'b0, out_valid}, 32'h1);
                check("stream_count", 32'(dut.u_fifo.count), 32'h1);
            end
            tick();
        end
        issue_valid = 1'b0;
        drain("drain_stream");
        check("stream_accepts", n_acc - a0, 100);
        check("stream_pops", n_pop - p0, 100);

        // Reset with two results queued and three in flight
        out_ready = 1'b0;
        issue_valid = 1'b1;
        nxt = mk(1'b0, 7'h21, 16'h1111, 1'b0, 1'b1);
        tick();
        nxt = mk(1'b1, 7'h22, 16'h2222, 1'b0, 1'b0);
        tick();
        issue_valid = 1'b0;
        repeat (4) tick();
        check("mid_pre_valid", {31'b0, out_valid}, 32'h1);
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt = mk(1'b0, 7'(i + 3), 16'hC0DE, 1'b0, 1'b0);
            tick();
        end
        issue_valid = 1'b0;
        check("mid_pre_sticky", {31'b0, sticky_unf}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'h0);
        check("mid_rst_ready", {31'b0, issue_ready}, 32'h1);
        check("mid_rst_data", {8'b0, out_data}, 32'h0);
        check("mid_rst_sticky", {30'b0, sticky_ovf, sticky_unf}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("mid_no_stale", {31'b0, out_valid}, 32'h0);
        end
        check("mid_final_ready", {31'b0, issue_ready}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
